// File: rtl/match_logger.sv
// match_logger: counts rising edges of the detector's match level, pulses once per match and
// logs a timestamp per match into a show-ahead FIFO drained over evt_valid/evt_ready.
// Ports: clk/rst_n (sync, active-low), match_in, clr, evt_ready -> evt_valid, evt_stamp,
// match_pulse, match_count, fifo_level, overflow. Optional MATCH_LOGGER_DROP_OLDEST_EN evicts the head on overflow.
module match_logger #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     match_in,
  input  logic                     clr,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [TS_W-1:0]          evt_stamp,
  output logic                     match_pulse,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic             match_q;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [TS_W-1:0]  last_q, last_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic rise, empty, full, pop, drop, wr_en, rd_en;

  always_comb begin
    rise  = match_in & ~match_q;
    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    // evt_ready is ignored while empty, so a push into an empty FIFO never pairs with a pop.
    pop   = ~empty & evt_ready;
    drop  = rise & full & ~pop;
`ifdef MATCH_LOGGER_DROP_OLDEST_EN
    // Evict the head to make room: a drop becomes a simultaneous read and write.
    wr_en = rise;
    rd_en = pop | drop;
`else
    wr_en = rise & ~drop;
    rd_en = pop;
`endif
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    ts_d     = ts_q + TS_W'(1);

    // Clear-then-apply: clr zeroes first, then this cycle's event/drop still lands.
    if (clr) begin
      cnt_d = rise ? CNT_W'(1) : '0;
      ovf_d = drop;
    end else begin
      cnt_d = (rise && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
      ovf_d = ovf_q | drop;
    end

    // Remember the popped head so evt_stamp can keep showing it once the FIFO runs empty.
    last_d = pop ? mem_q[rd_ptr_q] : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q  <= 1'b0;
      ts_q     <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      match_q  <= match_in;
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      pulse_q  <= rise;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: reads are masked by the level while empty.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign evt_valid   = ~empty;
  assign evt_stamp   = empty ? last_q : mem_q[rd_ptr_q];
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_logger.sv
module tb_match_logger;
  localparam int CNT_W = 8;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0, match_in = 1'b0, clr = 1'b0, evt_ready = 1'b0;

  logic             evt_valid, match_pulse, overflow;
  logic [TS_W-1:0]  evt_stamp;
  logic [CNT_W-1:0] match_count;
  logic [LW-1:0]    fifo_level;

  logic             s_valid, s_pulse, s_ovf;
  logic [TS_W-1:0]  s_stamp;
  logic [1:0]       s_count;
  logic [LW-1:0]    s_level;

  match_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .match_in(match_in), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_stamp(evt_stamp), .match_pulse(match_pulse),
    .match_count(match_count), .fifo_level(fifo_level), .overflow(overflow));

  match_logger #(.CNT_W(2), .TS_W(TS_W), .DEPTH(DEPTH)) sat_dut (
    .clk(clk), .rst_n(rst_n), .match_in(match_in), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(s_valid), .evt_stamp(s_stamp), .match_pulse(s_pulse),
    .match_count(s_count), .fifo_level(s_level), .overflow(s_ovf));

  always #5 clk = ~clk;

  // Reference model: a queue of stamps plus plain integer counters.
  bit m_prev, m_pulse, m_ovf;
  int m_ts, m_cnt, m_cnt2, m_last;
  int m_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_step();
    bit ev, dropped;
    if (!rst_n) begin
      m_prev = 0; m_pulse = 0; m_ovf = 0;
      m_ts = 0; m_cnt = 0; m_cnt2 = 0; m_last = 0;
      m_q.delete();
      return;
    end
    ev = match_in && !m_prev;
    dropped = 0;
    if (evt_ready && m_q.size() > 0) begin
      m_last = m_q[0];
      m_q.delete(0);
    end
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_ts);
      else begin
        dropped = 1;
`ifdef MATCH_LOGGER_DROP_OLDEST_EN
        m_q.delete(0);
        m_q.push_back(m_ts);
`endif
      end
    end
    if (clr) begin
      m_cnt  = ev ? 1 : 0;
      m_cnt2 = ev ? 1 : 0;
      m_ovf  = dropped;
    end else begin
      if (ev && m_cnt < 255) m_cnt++;
      if (ev && m_cnt2 < 3) m_cnt2++;
      m_ovf = m_ovf | dropped;
    end
    m_pulse = ev;
    m_prev  = match_in;
    m_ts    = (m_ts + 1) % 65536;
  endtask

  // One clock: DUT and model both consume the inputs present at the edge; outputs sampled #1 later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; match_in = 0; clr = 0; evt_ready = 0;
    cyc();
    rst_n = 1;
  endtask

  // Two idle cycles after reset, then n events spaced 2 cycles apart: stamps 2,4,6,...
  task automatic fire_events(input int n);
    match_in = 0;
    cyc(); cyc();
    for (int i = 0; i < n; i++) begin
      match_in = 1; cyc();
      match_in = 0; cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 0; match_in = 1; evt_ready = 1; clr = 0;
    cyc(); cyc();
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid actual=%0b required=0", evt_valid); else n_pass++;
    n_checks++; if (fifo_level !== '0) $display("FAIL reset_level actual=%0d required=0", fifo_level); else n_pass++;
    n_checks++; if (evt_stamp !== '0) $display("FAIL reset_stamp actual=%0d required=0", evt_stamp); else n_pass++;
    n_checks++; if (match_count !== '0) $display("FAIL reset_count actual=%0d required=0", match_count); else n_pass++;
    n_checks++; if (match_pulse !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_pulse_ovf actual=%0b%0b required=00", match_pulse, overflow); else n_pass++;
  endtask

  task automatic test_first_match();
    int pulses;
    do_reset();
    match_in = 0;
    repeat (10) cyc();
    pulses = 0;
    match_in = 1;
    repeat (3) begin cyc(); if (match_pulse === 1'b1) pulses++; end
    match_in = 0;
    cyc(); if (match_pulse === 1'b1) pulses++;
    n_checks++; if (pulses != 1) $display("FAIL first_pulses actual=%0d required=1", pulses); else n_pass++;
    n_checks++; if (match_count !== 8'd1) $display("FAIL first_count actual=%0d required=1", match_count); else n_pass++;
    n_checks++; if (fifo_level !== 3'd1) $display("FAIL first_level actual=%0d required=1", fifo_level); else n_pass++;
    n_checks++; if (evt_stamp !== 16'd10) $display("FAIL first_stamp actual=%0d required=10", evt_stamp); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [TS_W-1:0] exp_head;
`ifdef MATCH_LOGGER_DROP_OLDEST_EN
    exp_head = 16'd4;
`else
    exp_head = 16'd2;
`endif
    do_reset();
    evt_ready = 0;
    fire_events(5);
    n_checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level actual=%0d required=4", fifo_level); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag actual=%0b required=1", overflow); else n_pass++;
    n_checks++; if (evt_stamp !== exp_head) $display("FAIL ovf_head actual=%0d required=%0d", evt_stamp, exp_head); else n_pass++;
    n_checks++; if (match_count !== 8'd5) $display("FAIL ovf_count actual=%0d required=5", match_count); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fire_events(4);
    n_checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0)
      $display("FAIL fullpop_pre actual=lvl%0d ovf%0b required=lvl4 ovf0", fifo_level, overflow); else n_pass++;
    match_in = 1; evt_ready = 1;
    cyc();
    match_in = 0; evt_ready = 0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf actual=%0b required=0", overflow); else n_pass++;
    n_checks++; if (fifo_level !== 3'd4) $display("FAIL fullpop_level actual=%0d required=4", fifo_level); else n_pass++;
    n_checks++; if (evt_stamp !== 16'd4) $display("FAIL fullpop_head actual=%0d required=4", evt_stamp); else n_pass++;
  endtask

  task automatic test_saturate();
    int exp_sat[5] = '{1, 2, 3, 3, 3};
    do_reset();
    match_in = 0; cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      match_in = 1; cyc();
      n_checks++; if (s_count !== 2'(exp_sat[i]))
        $display("FAIL sat_count[%0d] actual=%0d required=%0d", i, s_count, exp_sat[i]); else n_pass++;
      match_in = 0; cyc();
    end
  endtask

  task automatic test_clr();
    do_reset();
    fire_events(7);
    n_checks++; if (match_count !== 8'd7 || overflow !== 1'b1)
      $display("FAIL clr_pre actual=cnt%0d ovf%0b required=cnt7 ovf1", match_count, overflow); else n_pass++;
    match_in = 1; clr = 1; evt_ready = 1;
    cyc();
    match_in = 0; clr = 0; evt_ready = 0;
    n_checks++; if (match_count !== 8'd1) $display("FAIL clr_count actual=%0d required=1", match_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf actual=%0b required=0", overflow); else n_pass++;
    n_checks++; if (fifo_level !== 3'd4) $display("FAIL clr_level actual=%0d required=4", fifo_level); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fire_events(3);
    rst_n = 0; match_in = 1; evt_ready = 1;
    cyc();
    n_checks++; if (fifo_level !== '0 || evt_valid !== 1'b0)
      $display("FAIL midrst_fifo actual=lvl%0d vld%0b required=lvl0 vld0", fifo_level, evt_valid); else n_pass++;
    n_checks++; if (evt_stamp !== '0 || match_count !== '0 || match_pulse !== 1'b0 || overflow !== 1'b0)
      $display("FAIL midrst_outs actual=st%0d cnt%0d p%0b o%0b required=all0", evt_stamp, match_count, match_pulse, overflow); else n_pass++;
    // match_in high on the first edge after reset counts, and logs ts=0.
    rst_n = 1; evt_ready = 0;
    cyc();
    n_checks++; if (match_count !== 8'd1 || match_pulse !== 1'b1)
      $display("FAIL postrst_match actual=cnt%0d p%0b required=cnt1 p1", match_count, match_pulse); else n_pass++;
    n_checks++; if (evt_stamp !== '0 || fifo_level !== 3'd1)
      $display("FAIL postrst_entry actual=st%0d lvl%0d required=st0 lvl1", evt_stamp, fifo_level); else n_pass++;
    match_in = 0;
  endtask

  task automatic test_random();
    logic [TS_W-1:0] e_stamp;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      match_in  = $urandom_range(0, 1);
      evt_ready = ($urandom_range(0, 3) == 0);
      clr       = ($urandom_range(0, 29) == 0);
      cyc();
      e_stamp = (m_q.size() > 0) ? TS_W'(m_q[0]) : TS_W'(m_last);
      n_checks++; if (evt_valid !== (m_q.size() > 0) || fifo_level !== LW'(m_q.size()))
        $display("FAIL rnd_fifo cyc%0d actual=vld%0b lvl%0d required=lvl%0d", i, evt_valid, fifo_level, m_q.size()); else n_pass++;
      n_checks++; if (evt_stamp !== e_stamp)
        $display("FAIL rnd_stamp cyc%0d actual=%0d required=%0d", i, evt_stamp, e_stamp); else n_pass++;
      n_checks++; if (match_count !== CNT_W'(m_cnt) || s_count !== 2'(m_cnt2))
        $display("FAIL rnd_count cyc%0d actual=%0d/%0d required=%0d/%0d", i, match_count, s_count, m_cnt, m_cnt2); else n_pass++;
      n_checks++; if (match_pulse !== m_pulse || overflow !== m_ovf)
        $display("FAIL rnd_pulse_ovf cyc%0d actual=%0b%0b required=%0b%0b", i, match_pulse, overflow, m_pulse, m_ovf); else n_pass++;
      n_checks++; if (s_valid !== evt_valid || s_stamp !== e_stamp || s_level !== LW'(m_q.size()) ||
                      s_pulse !== m_pulse || s_ovf !== m_ovf)
        $display("FAIL rnd_sat_inst cyc%0d actual=%0b %0d %0d %0b %0b", i, s_valid, s_stamp, s_level, s_pulse, s_ovf); else n_pass++;
    end
    rst_n = 1; clr = 0; evt_ready = 0; match_in = 0;
  endtask

  initial begin
    test_reset();
    test_first_match();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=no_finish required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/match_logger.md
# match_logger

Downstream consumer of the 1-2-3 sequence detector's `ans` level output. Detects each rising edge of that level, meaning one completed match, and keeps a saturating match count. It also emits a one-cycle match pulse and logs a free-running cycle timestamp for each match into a small show-ahead FIFO. A host drains the FIFO over a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 8: width of the match counter.
- `TS_W`, default 16: width of the timestamp counter and of the FIFO entries.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, 2 or more.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `match_in`  in  1  level from the detector's `ans`; it is a registered signal.
- `clr`  in  1  synchronous clear of `match_count` and `overflow`.
- `evt_ready`  in  1  host accepts the head entry.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_stamp`  out  TS_W  timestamp at the FIFO head.
- `match_pulse`  out  1  one-cycle pulse per detected match.
- `match_count`  out  CNT_W  saturating number of matches.
- `fifo_level`  out  $clog2(DEPTH)+1  current number of FIFO entries.
- `overflow`  out  1  sticky flag: an event was dropped.

## Operation
- Edge detect: `match_d` registers `match_in`.
  - `edge = match_in & ~match_d`, evaluated at each rising edge of `clk`.
  - A `match_in` level held for N cycles yields exactly one event.
- Timestamp: `ts` is a TS_W counter.
  - It increments every cycle and wraps from all-ones to 0.
  - An event logs the value `ts` holds before the edge at which `edge` is sampled.
- Counter: on `edge`, `match_count` increments and saturates at 2^CNT_W-1 with no wrap.
- Pulse: `match_pulse` is registered and equals `edge` of the previous clock edge.
- FIFO:
  - push = `edge`; pop = `evt_valid & evt_ready`.
  - The FIFO is show-ahead: `evt_stamp` always shows the head entry.
  - When empty, `evt_stamp` holds its last value and `evt_ready` is ignored.
  - Push without pop, not full: write the entry; level +1.
  - Pop without push: level -1.
  - Push and pop together, any level including full: both occur; level unchanged; no drop.
  - Push and pop together when empty: pop is not possible; push occurs; level becomes 1.
  - Full, push, no pop: the event is dropped as described in Configuration, and `overflow` is set.
- `clr` uses clear-then-apply:
  - `match_count` becomes `edge ? 1 : 0`.
  - `overflow` becomes 1 only if a drop occurs in the same cycle.
  - `clr` does not affect the FIFO, `ts` or `match_pulse`.

## Timing
- Reset (`rst_n`=0 at a clock edge) sets the following, regardless of any other input:
  - `match_d`=0, `ts`=0, `match_count`=0, `match_pulse`=0, `overflow`=0.
  - FIFO empty, so `evt_valid`=0 and `fifo_level`=0; `evt_stamp`=0.
- Reset mid-operation discards all FIFO entries.
- If `match_in` is 1 on the first edge after reset, it counts as a match.
- Event latency: `match_in` 0→1 seen at edge k gives the following after edge k:
  - `match_pulse`=1 for one cycle and `match_count` updated.
  - Entry written; `evt_valid`=1 if the FIFO was previously empty.
- Pop: the head advances on the edge where `evt_valid & evt_ready`=1; the next entry is visible in the following cycle.
- Minimum event spacing is 2 cycles (1,0,1 on `match_in`); back-to-back events are each logged.

## Configuration
- Macro `MATCH_LOGGER_DROP_OLDEST_EN`.
- Undefined (default): on a full FIFO with push and no pop, the new event is discarded. Entries and `fifo_level`=DEPTH are unchanged.
- Defined: on the same condition, the head entry is discarded and the new entry is written at the tail. `fifo_level` stays DEPTH and `evt_stamp` shows the second-oldest entry.
- In both modes `overflow` is set and `match_count` still increments.

## Test plan
- Reset release, `match_in`=0 for 10 cycles, then `match_in`=1 for 3 cycles:
  - `match_count`=1 and a single `match_pulse`.
  - One entry, `evt_stamp`=10.
- DEPTH=4, `evt_ready`=0, 5 events at ts=2,4,6,8,10:
  - `fifo_level`=4 and `overflow`=1.
  - Head `evt_stamp`=2 by default; 4 with `MATCH_LOGGER_DROP_OLDEST_EN`.
  - `match_count`=5.
- FIFO full and event with `evt_ready`=1 in the same cycle: no drop; `overflow` stays 0; level stays 4; head advances.
- CNT_W=2, 5 events: `match_count` reads 1,2,3,3,3.
- `clr` in the same cycle as an event with `overflow`=1 and `match_count`=7: next cycle `match_count`=1 and `overflow`=0.
- `rst_n`=0 with 3 entries queued: next cycle `fifo_level`=0, `evt_valid`=0, `ts`=0, all outputs 0.
